// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Read data returned to the owner when the memory never acknowledges.
  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_grant_select.sv
// Grant selection for the memory port: data has priority, but a streak
// counter forces a fetch grant after STARVE_LIMIT consecutive data grants
// taken while fetch was waiting.
module arb_grant_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_valid,
  output logic grant_data
);

  localparam int unsigned STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [STREAK_W-1:0] streak;
  logic                starved;

  // Combinational pick from the live requests and the registered streak.
  always_comb begin
    starved     = (streak == STREAK_W'(STARVE_LIMIT));
    grant_valid = arb_en & (if_req | d_req);
    grant_data  = d_req & ~(if_req & starved);
  end

  // Streak of data grants taken over a pending fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_valid) begin
      if (grant_data && if_req) begin
        if (!starved) streak <= streak + STREAK_W'(1);
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and
// load/store. One access in flight: IDLE -> ACCESS -> RESP -> IDLE.
// Optional build macro MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES
// ACCESS cycles without m_ack, returning ERR_RDATA with a bus_err pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic              m_byte,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              owner,
  output logic              busy,
  output logic              bus_err
);

  arb_state_t state;
  logic       grant_valid;
  logic       grant_data;

  arb_grant_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (state == IDLE),
    .if_req     (if_req),
    .d_req      (d_req),
    .grant_valid(grant_valid),
    .grant_data (grant_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Last ACCESS cycle allowed before the access is abandoned.
  always_comb begin
    tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  end
`else
  assign bus_err = 1'b0;
`endif

  // Transaction FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_byte   <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      owner    <= OWN_FETCH;
      busy     <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt  <= '0;
      bus_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state <= ACCESS;
            m_req <= 1'b1;
            busy  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (grant_data) begin
              owner   <= OWN_DATA;
              m_we    <= d_we;
              m_byte  <= d_byte;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              owner   <= OWN_FETCH;
              m_we    <= 1'b0;
              m_byte  <= 1'b0;
              m_addr  <= if_addr;
              m_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (m_ack) begin
            state <= RESP;
            m_req <= 1'b0;
            if (owner == OWN_DATA) begin
              d_ack <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= m_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            state   <= RESP;
            m_req   <= 1'b0;
            bus_err <= 1'b1;
            if (owner == OWN_DATA) begin
              d_ack   <= 1'b1;
              d_rdata <= DATA_W'(ERR_RDATA);
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= DATA_W'(ERR_RDATA);
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          bus_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: requester drivers push
// expectations, a memory responder supplies ROM data with random waits, and
// a negedge monitor checks grants, port fields and acks against a
// transaction-level reference of the arbitration rules.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned TMO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic        d_byte = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic        m_byte;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        owner;
  logic        busy;
  logic        bus_err;

  mem_port_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .STARVE_LIMIT  (LIMIT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_ack  (if_ack),
    .if_rdata(if_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_byte  (d_byte),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_byte  (m_byte),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .owner   (owner),
    .busy    (busy),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          mon_en = 1'b0;
  bit          mem_hold = 1'b0;
  logic [31:0] fq[$];
  dreq_t       dq[$];
  int unsigned streak_m = 0;
  int unsigned forced = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fetch requester: hold if_req until if_ack, bounded wait.
  task automatic fetch_txn(input int unsigned gap, input logic [31:0] addr);
    bit done = 1'b0;
    @(posedge clk); #1;
    repeat (gap) begin @(posedge clk); #1; end
    fq.push_back(addr);
    if_addr = addr;
    if_req  = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (if_ack) begin done = 1'b1; break; end
    end
    if_req = 1'b0;
    if (!done) chk("fetch_ack_timeout", 0, 1);
  endtask

  // Load/store requester: hold d_req until d_ack, bounded wait.
  task automatic data_txn(input int unsigned gap, input logic we, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bit    done = 1'b0;
    dreq_t r;
    @(posedge clk); #1;
    repeat (gap) begin @(posedge clk); #1; end
    r.we = we; r.byt = byt; r.addr = addr; r.wdata = wdata;
    dq.push_back(r);
    d_we = we; d_byte = byt; d_addr = addr; d_wdata = wdata;
    d_req = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (d_ack) begin done = 1'b1; break; end
    end
    d_req = 1'b0;
    if (!done) chk("data_ack_timeout", 0, 1);
  endtask

  task automatic rand_data(input int unsigned gap);
    logic        byt;
    logic [31:0] a;
    byt = 1'($urandom_range(0, 1));
    a   = $urandom;
    if (!byt) a[1:0] = 2'b00;
    data_txn(gap, 1'($urandom_range(0, 1)), byt, a, $urandom);
  endtask

  // Memory responder: random 0..3 wait states, spurious m_ack while idle.
  int unsigned wl = 0;
  bit          act = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      m_ack   = 1'b0;
      m_rdata = $urandom;
      if (m_req && !mem_hold) begin
        if (!act) begin act = 1'b1; wl = $urandom_range(0, 3); end
        if (wl == 0) begin
          m_ack   = 1'b1;
          m_rdata = rom(m_addr);
          act     = 1'b0;
        end else begin
          wl--;
        end
      end else if (!m_req) begin
        act   = 1'b0;
        m_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor / scoreboard.
  logic        p_if = 0, p_d = 0, p_mreq = 0, p_mack = 0, p_ifack = 0, p_dack = 0;
  logic [31:0] p_ifrd = '0, p_drd = '0, l_addr = '0, l_wdata = '0;
  logic [2:0]  l_ctrl = '0;
  logic        exp_own;
  logic [31:0] fa;
  dreq_t       dr;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        streak_m = 0;
      end else if (mon_en) begin
        chk("busy", busy, m_req | if_ack | d_ack);
        if (m_req && !p_mreq) begin
          exp_own = p_d && !(p_if && streak_m == LIMIT);
          if (p_if && p_d && !exp_own) forced++;
          chk("grant_owner", owner, exp_own);
          if (exp_own && p_if) begin
            if (streak_m < LIMIT) streak_m++;
          end else begin
            streak_m = 0;
          end
          if (owner) begin
            if (dq.size() == 0) chk("data_grant_unrequested", 0, 1);
            else begin
              chk("data_m_addr", m_addr, dq[0].addr);
              chk("data_m_ctrl", {m_we, m_byte}, {dq[0].we, dq[0].byt});
              if (dq[0].we) chk("data_m_wdata", m_wdata, dq[0].wdata);
            end
          end else begin
            if (fq.size() == 0) chk("fetch_grant_unrequested", 0, 1);
            else begin
              chk("fetch_m_addr", m_addr, fq[0]);
              chk("fetch_m_ctrl", {m_we, m_byte}, 2'b00);
            end
          end
          l_addr = m_addr; l_wdata = m_wdata; l_ctrl = {owner, m_we, m_byte};
        end else if (!p_mreq && !p_ifack && !p_dack && (p_if || p_d)) begin
          chk("grant_missing", m_req, 1);
        end
        if (m_req && p_mreq) begin
          chk("m_hold_addr_wdata", {m_addr, m_wdata}, {l_addr, l_wdata});
          chk("m_hold_ctrl", {owner, m_we, m_byte}, l_ctrl);
        end
        if (p_mreq && p_mack) begin
          chk("m_req_drop", m_req, 0);
          chk("ack_route", {if_ack, d_ack}, owner ? 2'b01 : 2'b10);
        end
        if (p_ifack || p_dack) chk("ack_pulse", {if_ack, d_ack}, 2'b00);
        if (if_ack) begin
          chk("if_ack_cause", p_mreq && p_mack, 1);
          chk("if_bus_err", bus_err, 0);
          chk("d_rdata_hold", d_rdata, p_drd);
          if (fq.size() == 0) chk("if_ack_unrequested", 0, 1);
          else begin
            fa = fq.pop_front();
            chk("if_rdata", if_rdata, rom(fa));
          end
        end
        if (d_ack) begin
          chk("d_ack_cause", p_mreq && p_mack, 1);
          chk("d_bus_err", bus_err, 0);
          chk("if_rdata_hold", if_rdata, p_ifrd);
          if (dq.size() == 0) chk("d_ack_unrequested", 0, 1);
          else begin
            dr = dq.pop_front();
            if (dr.we) chk("d_rdata_write_hold", d_rdata, p_drd);
            else       chk("d_rdata", d_rdata, rom(dr.addr));
          end
        end
      end
      p_if = if_req; p_d = d_req; p_mreq = m_req; p_mack = m_ack;
      p_ifack = if_ack; p_dack = d_ack; p_ifrd = if_rdata; p_drd = d_rdata;
    end
  end

  // Backstop against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int unsigned cyc;
  logic [31:0] hold_if;
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {if_ack, d_ack, m_req, m_we, m_byte, owner, busy, bus_err}, 8'h00);
    chk("reset_m_bus", {m_addr, m_wdata}, 64'h0);
    chk("reset_rdata", {if_rdata, d_rdata}, 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    fork
      repeat (40) fetch_txn($urandom_range(0, 3), $urandom & 32'hFFFF_FFFC);
      repeat (40) rand_data($urandom_range(0, 3));
    join
    fork
      repeat (30) fetch_txn(0, $urandom & 32'hFFFF_FFFC);
      repeat (30) rand_data(0);
    join
    chk("forced_fetch_seen", forced > 0, 1);

    data_txn(0, 1'b0, 1'b1, 32'h0000_0203, 32'h0);
    data_txn(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0055);
    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", fq.size() + dq.size(), 0);

    // Reset while an access is outstanding.
    mon_en   = 1'b0;
    mem_hold = 1'b1;
    if_addr  = 32'h40;
    if_req   = 1'b1;
    @(posedge clk); #1;
    chk("rst_test_grant", m_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_access", {m_req, if_ack, d_ack, busy, owner}, 5'b0);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_ack", {if_ack, d_ack}, 2'b00);
    rst      = 1'b0;
    mem_hold = 1'b0;
    mon_en   = 1'b1;
    fetch_txn(0, 32'h0000_0010);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_fetch_drained", fq.size(), 0);

`ifdef MEM_TIMEOUT_EN
    mon_en   = 1'b0;
    mem_hold = 1'b1;
    hold_if  = if_rdata;
    if_addr  = 32'h80;
    if_req   = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (if_ack) break;
    end
    if_req = 1'b0;
    chk("timeout_edges", cyc, 9);
    chk("timeout_ack_err", {if_ack, bus_err}, 2'b11);
    chk("timeout_rdata", if_rdata, ERR_RDATA);
    @(posedge clk); #1;
    chk("timeout_err_pulse", {if_ack, bus_err}, 2'b00);
    mem_hold = 1'b0;
`else
    hold_if = if_rdata;
    cyc = 0;
    chk("bus_err_tied", bus_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
